sd4_window_gen: RTL and testbench
=================================

Name: sd4_window_gen

Overview:
Upstream feeder for the 3x3 SD4 convolution MAC. It accepts a raster-order stream of 8-bit pixels and builds 3x3 windows with two internal line buffers. Each window is presented as one 72-bit word matching the MAC's `image` input, with a one-cycle `win_valid` strobe. Weights and `exp_bias` come from a separate path and are outside this block.

Parameters:
IMG_W, 8, pixels per row; legal range 3..1024.
IMG_H, 8, rows per frame; legal range 3..1024.
PIX_W, 8, bits per pixel; fixed at 8 for MAC compatibility.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
sof  input  1  start of frame; qualified by pix_valid; marks the current pixel as (row 0, col 0).
pix_valid  input  1  pix_in carries a pixel this cycle.
pix_in  input  8  pixel value, raster order (row-major, col 0 first).
image  output  72  3x3 window; registered.
win_valid  output  1  image holds a new valid window this cycle; 1-cycle pulse per window.
frame_done  output  1  1-cycle pulse after the last pixel of a frame (row IMG_H-1, col IMG_W-1) is accepted.
row_idx  output  10  row of the next expected pixel.
col_idx  output  10  column of the next expected pixel.

Behaviour:
- Reset (async assert, sync release):
  - image = 0, win_valid = 0, frame_done = 0, row_idx = 0, col_idx = 0.
  - Line buffer contents are don't-care; windows are never marked valid until two full rows have been refilled after reset.
- Accept: a pixel is accepted only when pix_valid = 1. When pix_valid = 0, all state holds and win_valid/frame_done are 0. There is no backpressure; the source paces the stream with pix_valid.
- Line buffers:
  - lb1 holds the previous row; lb0 holds the row before that. Each is IMG_W deep, implemented as a circular buffer addressed by col_idx.
  - On accept at column c: read old = lb1[c] and older = lb0[c]; write lb0[c] <= old and lb1[c] <= pix_in.
- Window shift: on accept, each 3-pixel window row shifts left by one column and the new column enters on the right.
  - Top row takes the new entry from lb0 (row r-2).
  - Middle row takes it from lb1 (row r-1).
  - Bottom row takes pix_in (row r).
- Packing, MSB first:
  - image[71:48] = top row: [71:64] col c-2, [63:56] col c-1, [55:48] col c.
  - image[47:24] = middle row, same column order.
  - image[23:0] = bottom row, same column order; image[7:0] is the newest pixel.
- Valid rule and latency:
  - win_valid = 1 exactly one cycle after accepting a pixel with row >= 2 and col >= 2.
  - No window spans a row boundary, so cols 0 and 1 of every row produce none.
  - Each frame yields (IMG_W-2)*(IMG_H-2) windows.
- image update: image updates on every accept, so it may change while win_valid = 0. It holds its value when no pixel is accepted.
- Counters:
  - col_idx increments per accept and wraps IMG_W-1 -> 0.
  - On that wrap, row_idx increments; row_idx wraps IMG_H-1 -> 0, and frame_done pulses in the following cycle.
  - The next frame continues seamlessly without sof.
- sof handling:
  - sof with pix_valid forces this pixel to be treated as (0,0); counters become (0,1) afterwards.
  - Mid-frame sof aborts the current frame: no frame_done, no windows until rows 0-1 of the new frame are refilled.
  - sof without pix_valid is ignored.
- Reset during a frame clears all state immediately; the next frame begins at (0,0) regardless of sof.

Test Plan:
1. IMG_W=4, IMG_H=4, pixels 0x00..0x0F consecutive with sof on the first -> first win_valid one cycle after pixel 0x0A; image = 72'h000102_040506_08090A.
2. Same run -> exactly 4 windows: ..._08090A, 72'h010203_050607_090A0B, 72'h040506_08090A_0C0D0E, 72'h050607_090A0B_0D0E0F; no win_valid after pixel 0x0C; frame_done pulses once, one cycle after pixel 0x0F.
3. Repeat test 1 with pix_valid toggling 1-0-1 (idle cycles inserted) -> identical window sequence and values; win_valid never asserted in idle cycles; image stable while idle.
4. Two back-to-back frames, second without sof, pixel values 0x10..0x1F -> second frame's first window = 72'h101112_141516_18191A; 8 windows total; 2 frame_done pulses.
5. sof asserted at pixel index 6 of a frame -> no frame_done for the aborted frame; next window appears one cycle after the 11th pixel following sof.
6. Assert rst mid-row (after pixel 0x09) -> image = 0, win_valid = 0, row_idx/col_idx = 0 immediately, without waiting for a clock edge; restarted stream reproduces test 1 exactly.

Source files
------------

// File: rtl/sd4_window_gen.sv
//------------------------------------------------------------------------------
// sd4_window_gen
//
// Builds 3x3 pixel windows from a raster-order 8-bit pixel stream for the
// SD4 convolution MAC. Two line buffers (lb1 = previous row, lb0 = the row
// before that) feed the top and middle rows of a 3-column shift window. The
// bottom row is fed directly from pix_in.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   sof        start of frame, qualified by pix_valid; forces pixel to (0,0)
//   pix_valid  pix_in carries a pixel this cycle (no backpressure)
//   pix_in     pixel value, raster order
//   image      registered 3x3 window, MSB = top-left, [7:0] = newest pixel
//   win_valid  1-cycle pulse when image holds a new complete window
//   frame_done 1-cycle pulse after the last pixel of a frame is accepted
//   row_idx    row of the next expected pixel
//   col_idx    column of the next expected pixel
//------------------------------------------------------------------------------
module sd4_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sof,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_in,
  output logic [9*PIX_W-1:0] image,
  output logic               win_valid,
  output logic               frame_done,
  output logic [9:0]         row_idx,
  output logic [9:0]         col_idx
);

  localparam int         AW       = $clog2(IMG_W);
  localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
  localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  logic [9:0]       eff_row;
  logic [9:0]       eff_col;
  logic [9:0]       next_row;
  logic [9:0]       next_col;
  logic [AW-1:0]    addr;
  logic             last_col;
  logic             last_row;
  logic [PIX_W-1:0] old_pix;
  logic [PIX_W-1:0] older_pix;

  // Position of the pixel on the input this cycle. A qualified sof overrides
  // the counters so the pixel is treated as (0,0), which also aborts any frame
  // in progress: the window rule below then suppresses output until two fresh
  // rows have passed through the line buffers.
  always_comb begin
    eff_row  = row_idx;
    eff_col  = col_idx;
    if (sof) begin
      eff_row = '0;
      eff_col = '0;
    end
    addr      = eff_col[AW-1:0];
    last_col  = (eff_col == LAST_COL);
    last_row  = (eff_row == LAST_ROW);
    next_col  = last_col ? 10'd0 : eff_col + 10'd1;
    next_row  = eff_row;
    if (last_col) begin
      next_row = last_row ? 10'd0 : eff_row + 10'd1;
    end
    old_pix   = lb1[addr];
    older_pix = lb0[addr];
  end

  // Line buffers as column-addressed circular buffers. On each accept the
  // previous-row entry ages into lb0 and the new pixel takes its place in lb1.
  // Contents need no reset because windows are only flagged valid once two
  // full rows have been rewritten.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb0[addr] <= old_pix;
      lb1[addr] <= pix_in;
    end
  end

  // Window shift register, position counters and output strobes. Each window
  // row shifts left by one pixel and takes its new right-hand column from
  // lb0 (top), lb1 (middle) and pix_in (bottom).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      image      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      row_idx    <= '0;
      col_idx    <= '0;
    end else if (pix_valid) begin
      image      <= {image[8*PIX_W-1:6*PIX_W], older_pix,
                     image[5*PIX_W-1:3*PIX_W], old_pix,
                     image[2*PIX_W-1:0],       pix_in};
      win_valid  <= (eff_row >= 10'd2) && (eff_col >= 10'd2);
      frame_done <= last_row && last_col;
      row_idx    <= next_row;
      col_idx    <= next_col;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd4_window_gen.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_sd4_window_gen
//
// Directed scenarios followed by a randomized stream for sd4_window_gen on a
// 4x4 image. A frame-array reference model tracks each accepted pixel's
// (row,col) from a running pixel count and builds the expected window
// directly from the 2D frame contents.
//------------------------------------------------------------------------------
module tb_sd4_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk;
  logic        rst;
  logic        sof;
  logic        pix_valid;
  logic [7:0]  pix_in;
  logic [71:0] image;
  logic        win_valid;
  logic        frame_done;
  logic [9:0]  row_idx;
  logic [9:0]  col_idx;

  int total;
  int bad;

  // Reference model state
  logic [7:0]  frame_px [H][W];
  int          cnt;
  logic        exp_wv;
  logic        exp_fd;
  logic [71:0] exp_img;
  logic        img_known;
  int          exp_row;
  int          exp_col;

  // Observation logs used by the scenario-level checks
  logic [71:0] win_log [$];
  int          fd_cnt;

  sd4_window_gen #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sof       (sof),
    .pix_valid (pix_valid),
    .pix_in    (pix_in),
    .image     (image),
    .win_valid (win_valid),
    .frame_done(frame_done),
    .row_idx   (row_idx),
    .col_idx   (col_idx)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts it and reports any difference
  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Model goes back to its post-reset state
  task automatic model_reset();
    cnt       = 0;
    exp_wv    = 1'b0;
    exp_fd    = 1'b0;
    exp_img   = '0;
    img_known = 1'b1;
    exp_row   = 0;
    exp_col   = 0;
  endtask

  // Compares every output against the model after a clock edge
  task automatic checkOutput(input string tag);
    chk({tag, ".win_valid"},  72'(win_valid),  72'(exp_wv));
    chk({tag, ".frame_done"}, 72'(frame_done), 72'(exp_fd));
    chk({tag, ".row_idx"},    72'(row_idx),    72'(exp_row));
    chk({tag, ".col_idx"},    72'(col_idx),    72'(exp_col));
    if (img_known) chk({tag, ".image"}, image, exp_img);
  endtask

  // Drives one cycle of input, advances the model, then checks outputs
  task automatic applyStimulus(input logic s, input logic v, input logic [7:0] p, input string tag);
    int r;
    int c;
    sof       = s;
    pix_valid = v;
    pix_in    = p;
    @(posedge clk);
    #1;
    if (v) begin
      if (s) cnt = 0;
      r = (cnt / W) % H;
      c = cnt % W;
      frame_px[r][c] = p;
      exp_wv = (r >= 2) && (c >= 2);
      exp_fd = (r == H - 1) && (c == W - 1);
      if (exp_wv) begin
        exp_img = {frame_px[r-2][c-2], frame_px[r-2][c-1], frame_px[r-2][c],
                   frame_px[r-1][c-2], frame_px[r-1][c-1], frame_px[r-1][c],
                   frame_px[r][c-2],   frame_px[r][c-1],   frame_px[r][c]};
        img_known = 1'b1;
      end else begin
        img_known = 1'b0;
      end
      cnt     = (cnt + 1) % (W * H);
      exp_row = (cnt / W) % H;
      exp_col = cnt % W;
    end else begin
      exp_wv = 1'b0;
      exp_fd = 1'b0;
    end
    checkOutput(tag);
    if (win_valid) win_log.push_back(image);
    if (frame_done) fd_cnt++;
  endtask

  function automatic logic [71:0] get_win(input int i);
    if (i < win_log.size()) return win_log[i];
    return 'x;
  endfunction

  // Empties the observation logs before a scenario
  task automatic clear_logs();
    win_log.delete();
    fd_cnt = 0;
  endtask

  // Checks the four windows and single frame_done of a 0x00..0x0F frame
  task automatic check_frame0(input string tag);
    chk({tag, ".win_count"}, 72'(win_log.size()), 72'd4);
    chk({tag, ".win0"}, get_win(0), 72'h000102_040506_08090A);
    chk({tag, ".win1"}, get_win(1), 72'h010203_050607_090A0B);
    chk({tag, ".win2"}, get_win(2), 72'h040506_08090A_0C0D0E);
    chk({tag, ".win3"}, get_win(3), 72'h050607_090A0B_0D0E0F);
    chk({tag, ".fd_count"}, 72'(fd_cnt), 72'd1);
  endtask

  // Directed scenarios followed by a randomized stream
  initial begin
    total     = 0;
    bad       = 0;
    fd_cnt    = 0;
    rst       = 1'b1;
    sof       = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame_px[r][c] = '0;
    model_reset();

    // Reset state while rst is held
    #3;
    chk("reset.image",      image,              72'd0);
    chk("reset.win_valid",  72'(win_valid),     72'd0);
    chk("reset.frame_done", 72'(frame_done),    72'd0);
    chk("reset.row_idx",    72'(row_idx),       72'd0);
    chk("reset.col_idx",    72'(col_idx),       72'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single frame 0x00..0x0F with sof on the first pixel
    $display("[TB] single frame");
    clear_logs();
    for (int i = 0; i < 16; i++) applyStimulus(i == 0, 1'b1, 8'(i), "t1");
    check_frame0("t2");

    // Same frame with an idle cycle after every pixel
    $display("[TB] frame with idle gaps");
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i == 0, 1'b1, 8'(i), "t3.px");
      applyStimulus(1'b0, 1'b0, 8'($urandom), "t3.idle");
    end
    check_frame0("t3");

    // Two back-to-back frames, the second without sof
    $display("[TB] back-to-back frames");
    clear_logs();
    for (int i = 0; i < 32; i++) applyStimulus(i == 0, 1'b1, 8'(i), "t4");
    chk("t4.win_count", 72'(win_log.size()), 72'd8);
    chk("t4.win4", get_win(4), 72'h101112_141516_18191A);
    chk("t4.win7", get_win(7), 72'h151617_191A1B_1D1E1F);
    chk("t4.fd_count", 72'(fd_cnt), 72'd2);

    // Frame aborted by sof at pixel index 6
    $display("[TB] mid-frame sof");
    clear_logs();
    for (int i = 0; i < 6; i++) applyStimulus(i == 0, 1'b1, 8'(8'h80 + i), "t5.abort");
    for (int i = 0; i < 16; i++) applyStimulus(i == 0, 1'b1, 8'(8'h40 + i), "t5.new");
    chk("t5.win_count", 72'(win_log.size()), 72'd4);
    chk("t5.win0", get_win(0), 72'h404142_444546_48494A);
    chk("t5.fd_count", 72'(fd_cnt), 72'd1);

    // Asynchronous reset mid-row, then restart without sof
    $display("[TB] async reset mid-row");
    clear_logs();
    for (int i = 0; i < 10; i++) applyStimulus(i == 0, 1'b1, 8'(i), "t6.pre");
    #1;
    rst       = 1'b1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    #1;
    chk("t6.image",     image,          72'd0);
    chk("t6.win_valid", 72'(win_valid), 72'd0);
    chk("t6.row_idx",   72'(row_idx),   72'd0);
    chk("t6.col_idx",   72'(col_idx),   72'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(i), "t6.post");
    check_frame0("t6");

    // Randomized pixels, pacing and occasional sof
    $display("[TB] randomized stream");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
                    8'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
